seq_divider: RTL and testbench

- Iterative signed/unsigned 16-bit divider for the single-cycle processor's DIV/REM path.
- One restoring shift-subtract step per cycle.
- A start/busy/done handshake lets the control unit stall PC update until the result is valid.
- This is the inverse-operation companion to the datapath's combinational add/sub unit: it repeatedly applies trial subtraction to undo multiplication.

---
 rtl/div_pkg.sv | 17 +
 rtl/seq_divider_if.sv | 27 ++
 rtl/div_step.sv | 33 +++
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Operand patterns for the 16-bit special cases (signed overflow).
  localparam logic [DIV_WIDTH-1:0] MIN_NEG = 16'h8000;
  localparam logic [DIV_WIDTH-1:0] NEG_ONE = 16'hFFFF;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit and the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divzero;
  logic             ovfl;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, divzero, ovfl
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, divzero, ovfl
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_trial_msb;

  // Shifted partial remainder needs WIDTH+1 bits; borrow-out marks a negative trial.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign {borrow, trial} = {1'b0, rem_sh} - {2'b00, divisor_i};

  // A successful trial is always below the divisor, so its top bit is zero.
  assign unused_trial_msb = trial[WIDTH];

  // Keep the trial when it did not go negative, otherwise restore.
  always_comb begin
    if (!borrow) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider: one restoring step per cycle,
// start/busy/done handshake, sticky divide-by-zero and overflow flags.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] NEG_ONE_W = '1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             bypass_q, bypass_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divzero_q, divzero_d;
  logic             ovfl_q, ovfl_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             dvd_neg, dvs_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];

  // Next-state and datapath control for IDLE/CALC/FIX/DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    bypass_d    = bypass_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divzero_d   = divzero_q;
    ovfl_d      = ovfl_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          quotient_d  = '0;
          remainder_d = '0;
          divzero_d   = 1'b0;
          ovfl_d      = 1'b0;
          cnt_d       = CW'(WIDTH);
          rem_d       = '0;
          qneg_d      = 1'b0;
          rneg_d      = 1'b0;
          bypass_d    = 1'b0;
          if (bus.divisor == '0) begin
            // Divide by zero: quotient all-ones, remainder is the raw dividend.
            // dvsr stays zero so FIX can tell the two bypass cases apart.
            state_d  = FIX;
            quo_d    = '1;
            rem_d    = bus.dividend;
            dvsr_d   = '0;
            bypass_d = 1'b1;
          end else if (bus.is_signed && bus.dividend == MIN_NEG_W &&
                       bus.divisor == NEG_ONE_W) begin
            state_d  = FIX;
            quo_d    = MIN_NEG_W;
            rem_d    = '0;
            dvsr_d   = NEG_ONE_W;
            bypass_d = 1'b1;
          end else begin
            // Work on magnitudes; the most-negative value maps to itself,
            // which is still the correct unsigned magnitude.
            state_d = CALC;
            quo_d   = dvd_neg ? -bus.dividend : bus.dividend;
            dvsr_d  = dvs_neg ? -bus.divisor  : bus.divisor;
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // Truncating division: remainder takes the dividend's sign.
        quotient_d  = (!bypass_q && qneg_q) ? -quo_q : quo_q;
        remainder_d = (!bypass_q && rneg_q) ? -rem_q : rem_q;
        divzero_d   = bypass_q && (dvsr_q == '0);
        ovfl_d      = bypass_q && (dvsr_q != '0);
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      bypass_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divzero_q   <= 1'b0;
      ovfl_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      bypass_q    <= bypass_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divzero_q   <= divzero_d;
      ovfl_q      <= ovfl_d;
    end
  end

  assign bus.busy      = (state_q == CALC) || (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.divzero   = divzero_q;
  assign bus.ovfl      = ovfl_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division with the two special cases.
  task automatic ref_div(input bit s, input logic [W-1:0] a, b,
                         output logic [W-1:0] q, r, output logic dz, ov);
    int sa, sb;
    dz = 1'b0; ov = 1'b0;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000; r = '0; ov = 1'b1;
    end else if (s) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      q = W'(sa / sb); r = W'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  function automatic int exp_lat(input bit s, input logic [W-1:0] a, b);
    if (b == 0 || (s && a == 16'h8000 && b == 16'hFFFF)) return 3;
    return W + 3;
  endfunction

  // Issue one operation; cycle 1 is the cycle start is presented in.
  task automatic run_op(input bit s, input logic [W-1:0] a, b,
                        output int lat, output logic [W-1:0] q, r,
                        output logic dz, ov, output logic busy_done,
                        output logic busy_gap, output logic [1:0] flags0,
                        output int extra_done, output logic held);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    flags0 = {bus.divzero, bus.ovfl};
    lat = -1; q = 'x; r = 'x; dz = 1'bx; ov = 1'bx; busy_done = 1'bx;
    busy_gap = 1'b0; extra_done = 0; held = 1'b1;
    k = 2;
    while (lat < 0 && k <= W + 12) begin
      if (bus.done) begin
        lat = k; q = bus.quotient; r = bus.remainder;
        dz = bus.divzero; ov = bus.ovfl; busy_done = bus.busy;
      end else begin
        if (!bus.busy) busy_gap = 1'b1;
        @(negedge clk);
        k++;
      end
    end
    if (lat >= 0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (bus.done) extra_done++;
        if (bus.quotient !== q || bus.remainder !== r) held = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 16'd9; bus.divisor = 16'd2;
    repeat (3) @(negedge clk);
    total++; if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.divzero, bus.ovfl} !== '0) begin
      bad++; $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h want all 0", bus.busy, bus.done, bus.quotient, bus.remainder); end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_basic();
    logic s_t [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] a_t [3] = '{16'd100, 16'hFF9C, 16'd100};
    logic [W-1:0] b_t [3] = '{16'd7, 16'd7, 16'hFFF9};
    logic [W-1:0] q_t [3] = '{16'd14, 16'hFFF2, 16'hFFF2};
    logic [W-1:0] r_t [3] = '{16'd2, 16'hFFFE, 16'd2};
    int lat, xd; logic [W-1:0] q, r, eq, er; logic dz, ov, edz, eov, bd, bg, hd; logic [1:0] f0;
    for (int i = 0; i < 3; i++) begin
      run_op(s_t[i], a_t[i], b_t[i], lat, q, r, dz, ov, bd, bg, f0, xd, hd);
      ref_div(s_t[i], a_t[i], b_t[i], eq, er, edz, eov);
      total++; if ({q, r} !== {q_t[i], r_t[i]}) begin
        bad++; $display("FAIL basic%0d_const: got q=%h r=%h want q=%h r=%h", i, q, r, q_t[i], r_t[i]); end
      total++; if ({q, r, dz, ov} !== {eq, er, edz, eov}) begin
        bad++; $display("FAIL basic%0d_model: got q=%h r=%h dz=%b ov=%b want %h %h %b %b", i, q, r, dz, ov, eq, er, edz, eov); end
      total++; if (lat !== W + 3) begin
        bad++; $display("FAIL basic%0d_latency: got %0d want %0d", i, lat, W + 3); end
      total++; if ({bd, bg, xd != 0, hd} !== 4'b0001) begin
        bad++; $display("FAIL basic%0d_handshake: busy_at_done=%b busy_gap=%b extra_done=%0d held=%b want 0 0 0 1", i, bd, bg, xd, hd); end
    end
  endtask

  task automatic test_divzero();
    int lat, xd; logic [W-1:0] q, r; logic dz, ov, bd, bg, hd; logic [1:0] f0;
    run_op(1'b0, 16'h1234, 16'h0000, lat, q, r, dz, ov, bd, bg, f0, xd, hd);
    total++; if ({q, r, dz, ov} !== {16'hFFFF, 16'h1234, 1'b1, 1'b0}) begin
      bad++; $display("FAIL divzero_result: got q=%h r=%h dz=%b ov=%b want ffff 1234 1 0", q, r, dz, ov); end
    total++; if (lat !== 3 || bd !== 1'b0 || xd != 0) begin
      bad++; $display("FAIL divzero_latency: got lat=%0d busy=%b extra=%0d want 3 0 0", lat, bd, xd); end
    total++; if (bus.divzero !== 1'b1) begin
      bad++; $display("FAIL divzero_held: got %b want 1", bus.divzero); end
    run_op(1'b0, 16'd50, 16'd5, lat, q, r, dz, ov, bd, bg, f0, xd, hd);
    total++; if (f0 !== 2'b00) begin
      bad++; $display("FAIL divzero_clear_on_start: got flags=%b want 00", f0); end
    total++; if ({q, r, dz} !== {16'd10, 16'd0, 1'b0}) begin
      bad++; $display("FAIL divzero_next: got q=%h r=%h dz=%b want 000a 0000 0", q, r, dz); end
  endtask

  task automatic test_ovfl();
    int lat, xd; logic [W-1:0] q, r; logic dz, ov, bd, bg, hd; logic [1:0] f0;
    run_op(1'b1, 16'h8000, 16'hFFFF, lat, q, r, dz, ov, bd, bg, f0, xd, hd);
    total++; if ({q, r, dz, ov} !== {16'h8000, 16'h0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL ovfl_signed: got q=%h r=%h dz=%b ov=%b want 8000 0000 0 1", q, r, dz, ov); end
    total++; if (lat !== 3) begin
      bad++; $display("FAIL ovfl_latency: got %0d want 3", lat); end
    run_op(1'b0, 16'h8000, 16'hFFFF, lat, q, r, dz, ov, bd, bg, f0, xd, hd);
    total++; if (f0 !== 2'b00) begin
      bad++; $display("FAIL ovfl_clear_on_start: got flags=%b want 00", f0); end
    total++; if ({q, r, dz, ov} !== {16'h0000, 16'h8000, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ovfl_unsigned: got q=%h r=%h dz=%b ov=%b want 0000 8000 0 0", q, r, dz, ov); end
    total++; if (lat !== W + 3) begin
      bad++; $display("FAIL ovfl_unsigned_latency: got %0d want %0d", lat, W + 3); end
  endtask

  task automatic test_ignore_start();
    int k, ndone, lat; logic [W-1:0] q, r;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 16'd1000; bus.divisor = 16'd13;
    @(negedge clk);
    bus.start = 1'b0;
    k = 2; ndone = 0; lat = -1; q = 'x; r = 'x;
    while (k <= W + 12) begin
      if (k == 5) begin
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 16'd7; bus.divisor = 16'd3;
      end else bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin lat = k; q = bus.quotient; r = bus.remainder; end
      end
      @(negedge clk);
      k++;
    end
    total++; if ({q, r} !== {16'd76, 16'd12}) begin
      bad++; $display("FAIL busy_start_result: got q=%h r=%h want 004c 000c", q, r); end
    total++; if (ndone != 1 || lat != W + 3) begin
      bad++; $display("FAIL busy_start_done: got pulses=%0d lat=%0d want 1 %0d", ndone, lat, W + 3); end
    // Second operation: a start presented during the DONE cycle must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 16'd200; bus.divisor = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < W + 10) begin @(negedge clk); k++; end
    bus.start = 1'b1; bus.dividend = 16'd5; bus.divisor = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    total++; if ({bus.busy, bus.done, bus.quotient, bus.remainder} !== {1'b0, 1'b0, 16'd22, 16'd2}) begin
      bad++; $display("FAIL done_cycle_start: got busy=%b done=%b q=%h r=%h want 0 0 0016 0002", bus.busy, bus.done, bus.quotient, bus.remainder); end
  endtask

  task automatic test_reset_midop();
    int lat, xd; logic [W-1:0] q, r, eq, er; logic dz, ov, edz, eov, bd, bg, hd, spur; logic [1:0] f0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 16'hD8F1; bus.divisor = 16'd37;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.divzero, bus.ovfl} !== '0) begin
      bad++; $display("FAIL midop_reset_outputs: got busy=%b done=%b q=%h r=%h want all 0", bus.busy, bus.done, bus.quotient, bus.remainder); end
    spur = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.done || bus.busy) spur = 1'b1; end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.done || bus.busy) spur = 1'b1;
    total++; if (spur !== 1'b0) begin
      bad++; $display("FAIL midop_reset_spurious: got activity=%b want 0", spur); end
    run_op(1'b0, 16'd60000, 16'd300, lat, q, r, dz, ov, bd, bg, f0, xd, hd);
    ref_div(1'b0, 16'd60000, 16'd300, eq, er, edz, eov);
    total++; if ({q, r, dz, ov} !== {eq, er, edz, eov} || lat != W + 3) begin
      bad++; $display("FAIL midop_reset_next: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", q, r, lat, eq, er, W + 3); end
  endtask

  task automatic test_random();
    int lat, xd, sel; logic [W-1:0] a, b, q, r, eq, er; logic s, dz, ov, edz, eov, bd, bg, hd; logic [1:0] f0;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom); a = W'($urandom); sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; end
      else if (sel < 4) b = W'($urandom_range(1, 255));
      else begin b = W'($urandom); if (b == 0) b = 16'd3; end
      run_op(s, a, b, lat, q, r, dz, ov, bd, bg, f0, xd, hd);
      ref_div(s, a, b, eq, er, edz, eov);
      total++; if ({q, r, dz, ov} !== {eq, er, edz, eov}) begin
        bad++; $display("FAIL rand%0d s=%b %h/%h: got q=%h r=%h dz=%b ov=%b want %h %h %b %b", i, s, a, b, q, r, dz, ov, eq, er, edz, eov); end
      total++; if (lat != exp_lat(s, a, b) || bd !== 1'b0 || bg !== 1'b0 || xd != 0 || f0 !== 2'b00) begin
        bad++; $display("FAIL rand%0d_timing: got lat=%0d busy_done=%b gap=%b extra=%0d flags0=%b want %0d 0 0 0 00", i, lat, bd, bg, xd, f0, exp_lat(s, a, b)); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_basic();
    test_divzero();
    test_ovfl();
    test_ignore_start();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
